// File: rtl/uart_tx_datapath.sv
// UART transmit datapath: captures a parallel payload, serialises it LSB-first,
// forms the parity bit and drives the registered serial line under FSM control.
module uart_tx_datapath #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_TYP,
    input  logic                  ser_en,
    input  logic [1:0]            mux_sel,
    input  logic                  par_load,
    output logic                  ser_done,
    output logic                  TX_OUT
);

    localparam int              CW        = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] data_d,  data_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic [CW-1:0]         cnt_d,   cnt_q;
    logic                  par_d,   par_q;
    logic                  tx_d,    tx_q;

    function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // Next-state logic for the holding, counter, shift, parity and line registers
    always_comb begin
        data_d  = data_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        tx_d    = tx_q;

        // A payload strobe during a frame is dropped so the frame stays coherent.
        if (data_valid && !ser_en) begin
            data_d = P_DATA;
        end else begin
            data_d = data_q;
        end

        if (ser_en) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = CNT_ZERO;
        end

        // Shift register holds on abort; the next frame start reloads it.
        if (ser_en && (cnt_q == CNT_ZERO)) begin
            shift_d = data_q;
        end else if (ser_en) begin
            shift_d = shift_q >> 1;
        end else begin
            shift_d = shift_q;
        end

        if (par_load) begin
            par_d = parity_of(data_q, PAR_TYP);
        end else begin
            par_d = par_q;
        end

        case (mux_sel)
            2'd0:    tx_d = 1'b0;
            2'd1:    tx_d = 1'b1;
            2'd2:    tx_d = shift_q[0];
            2'd3:    tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    // State registers; the line idles high out of reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            shift_q <= '0;
            cnt_q   <= CNT_ZERO;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            data_q  <= data_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // Left combinational: the FSM consumes it in the same cycle to leave its data state.
    assign ser_done = ser_en & (cnt_q == CNT_LAST);
    assign TX_OUT   = tx_q;

endmodule

// File: tb/tb_uart_tx_datapath.sv
// Self-checking bench for uart_tx_datapath: the bench plays the TX FSM and
// compares the serial line against frames built from a byte-level model.
module tb_uart_tx_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       PAR_TYP;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       par_load;
    logic       ser_done;
    logic       TX_OUT;

    int total = 0;
    int bad   = 0;

    logic obs_tx[$];
    logic obs_done[$];
    logic exp_tx[$];
    logic [7:0] model_data;

    uart_tx_datapath #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .P_DATA(P_DATA), .data_valid(data_valid),
        .PAR_TYP(PAR_TYP), .ser_en(ser_en), .mux_sel(mux_sel),
        .par_load(par_load), .ser_done(ser_done), .TX_OUT(TX_OUT)
    );

    always #5 clk = ~clk;

    // One FSM cycle: drive at negedge, sample ser_done mid-cycle, TX_OUT after the edge
    task automatic step(input logic se, input logic [1:0] ms, input logic pl,
                        input logic dv, input logic [7:0] pd);
        @(negedge clk);
        ser_en = se; mux_sel = ms; par_load = pl; data_valid = dv; P_DATA = pd;
        if (dv && !se) model_data = pd;
        #1;
        obs_done.push_back(ser_done);
        @(posedge clk);
        #1;
        obs_tx.push_back(TX_OUT);
    endtask

    // Idle cycle (optionally capturing b), start, 8 data, optional parity, stop
    task automatic run_frame(input logic [7:0] b, input bit cap, input bit pe, input bit pt,
                             input int dv_at, input logic [7:0] dv_data);
        obs_tx.delete();
        obs_done.delete();
        PAR_TYP = pt;
        step(1'b0, 2'd1, 1'b0, cap, b);
        step(1'b1, 2'd0, 1'b1, (dv_at == 0), dv_data);
        for (int i = 1; i <= 8; i++) step(1'b1, 2'd2, 1'b0, (dv_at == i), dv_data);
        if (pe) step(1'b0, 2'd3, 1'b0, 1'b0, 8'h00);
        step(1'b0, 2'd1, 1'b0, 1'b0, 8'h00);
    endtask

    // Expected line: idle 1, start 0, LSB-first data, parity making the ones count even/odd, stop 1
    task automatic build_expected(input logic [7:0] b, input bit pe, input bit pt);
        int ones;
        exp_tx.delete();
        exp_tx.push_back(1'b1);
        exp_tx.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_tx.push_back(b[i]);
        ones = $countones(b);
        if (pe) exp_tx.push_back(((ones % 2) == 1) ? ~pt : pt);
        exp_tx.push_back(1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b0; P_DATA = 8'h00; data_valid = 1'b0; PAR_TYP = 1'b0;
        ser_en = 1'b0; mux_sel = 2'd1; par_load = 1'b0;
        model_data = 8'h00;
        #12;
        total++;
        if (TX_OUT !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", TX_OUT); end
        total++;
        if (ser_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", ser_done); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_even_a5();
        run_frame(8'hA5, 1'b1, 1'b1, 1'b0, -1, 8'h00);
        build_expected(8'hA5, 1'b1, 1'b0);
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL a5_len got=%0d want=%0d", obs_tx.size(), exp_tx.size());
        end else begin
            for (int i = 0; i < obs_tx.size(); i++) begin
                total++;
                if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL a5_line idx=%0d got=%b want=%b", i, obs_tx[i], exp_tx[i]); end
            end
        end
        for (int i = 0; i < obs_done.size(); i++) begin
            total++;
            if (obs_done[i] !== (i == 9)) begin bad++; $display("FAIL a5_done idx=%0d got=%b want=%b", i, obs_done[i], (i == 9)); end
        end
    endtask

    task automatic test_odd_parity();
        logic [7:0] bytes [2] = '{8'hFF, 8'h80};
        bit         types [2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            run_frame(bytes[k], 1'b1, 1'b1, types[k], -1, 8'h00);
            build_expected(bytes[k], 1'b1, types[k]);
            total++;
            if (obs_tx.size() != exp_tx.size()) begin
                bad++; $display("FAIL par_len k=%0d got=%0d want=%0d", k, obs_tx.size(), exp_tx.size());
            end else begin
                total++;
                if (obs_tx[10] !== 1'b1) begin bad++; $display("FAIL par_bit k=%0d got=%b want=1", k, obs_tx[10]); end
                for (int i = 0; i < obs_tx.size(); i++) begin
                    total++;
                    if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL par_line k=%0d idx=%0d got=%b want=%b", k, i, obs_tx[i], exp_tx[i]); end
                end
            end
        end
    endtask

    task automatic test_no_parity();
        run_frame(8'h00, 1'b1, 1'b0, 1'b0, -1, 8'h00);
        build_expected(8'h00, 1'b0, 1'b0);
        total++;
        if (obs_tx.size() != 11) begin
            bad++; $display("FAIL nopar_len got=%0d want=11", obs_tx.size());
        end else begin
            for (int i = 0; i < obs_tx.size(); i++) begin
                total++;
                if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL nopar_line idx=%0d got=%b want=%b", i, obs_tx[i], exp_tx[i]); end
            end
        end
        for (int i = 0; i < obs_done.size(); i++) begin
            total++;
            if (obs_done[i] !== (i == 9)) begin bad++; $display("FAIL nopar_done idx=%0d got=%b want=%b", i, obs_done[i], (i == 9)); end
        end
    endtask

    task automatic test_mid_frame_dv();
        // 0xC3 strobed while data bit 2 is selected must not disturb the frame
        run_frame(8'h3C, 1'b1, 1'b1, 1'b0, 3, 8'hC3);
        build_expected(8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL middv_line idx=%0d got=%b want=%b", i, obs_tx[i], exp_tx[i]); end
        end
        run_frame(8'h00, 1'b0, 1'b1, 1'b0, -1, 8'h00);
        build_expected(8'h3C, 1'b1, 1'b0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL middv_replay idx=%0d got=%b want=%b", i, obs_tx[i], exp_tx[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2] = '{8'h55, 8'hAA};
        for (int k = 0; k < 2; k++) begin
            run_frame(bytes[k], 1'b1, 1'b1, 1'b1, -1, 8'h00);
            build_expected(bytes[k], 1'b1, 1'b1);
            for (int i = 0; i < exp_tx.size(); i++) begin
                total++;
                if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL b2b_line k=%0d idx=%0d got=%b want=%b", k, i, obs_tx[i], exp_tx[i]); end
            end
            total++;
            if (obs_done[9] !== 1'b1) begin bad++; $display("FAIL b2b_done k=%0d got=%b want=1", k, obs_done[9]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        obs_tx.delete();
        obs_done.delete();
        PAR_TYP = 1'b0;
        step(1'b0, 2'd1, 1'b0, 1'b1, 8'hA5);
        step(1'b1, 2'd0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 5; i++) step(1'b1, 2'd2, 1'b0, 1'b0, 8'h00);
        total++;
        if (TX_OUT !== 1'b0) begin bad++; $display("FAIL rstmid_pre got=%b want=0", TX_OUT); end
        #2;
        rst = 1'b0;
        model_data = 8'h00;
        #1;
        total++;
        if (TX_OUT !== 1'b1) begin bad++; $display("FAIL rstmid_async got=%b want=1", TX_OUT); end
        total++;
        if (ser_done !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", ser_done); end
        @(negedge clk);
        ser_en = 1'b0; mux_sel = 2'd1; rst = 1'b1;
        obs_tx.delete();
        obs_done.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs_tx[i] !== 1'b1 || obs_done[i] !== 1'b0) begin
                bad++; $display("FAIL rstmid_idle idx=%0d got=%b/%b want=1/0", i, obs_tx[i], obs_done[i]);
            end
        end
        // Holding register was cleared, so an uncaptured frame carries 0x00
        run_frame(8'h00, 1'b0, 1'b1, 1'b0, -1, 8'h00);
        build_expected(8'h00, 1'b1, 1'b0);
        for (int i = 0; i < exp_tx.size(); i++) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL rstmid_frame idx=%0d got=%b want=%b", i, obs_tx[i], exp_tx[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] other;
        bit pe, pt, cap;
        int dv_at;
        for (int n = 0; n < 24; n++) begin
            b     = 8'($urandom);
            other = 8'($urandom);
            pe    = 1'($urandom_range(0, 1));
            pt    = 1'($urandom_range(0, 1));
            cap   = ($urandom_range(0, 3) != 0);
            dv_at = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8);
            run_frame(b, cap, pe, pt, dv_at, other);
            build_expected(model_data, pe, pt);
            total++;
            if (obs_tx.size() != exp_tx.size()) begin
                bad++; $display("FAIL rand_len n=%0d got=%0d want=%0d", n, obs_tx.size(), exp_tx.size());
            end else begin
                for (int i = 0; i < exp_tx.size(); i++) begin
                    total++;
                    if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL rand_line n=%0d idx=%0d got=%b want=%b data=%h", n, i, obs_tx[i], exp_tx[i], model_data); end
                end
            end
            for (int i = 0; i < obs_done.size(); i++) begin
                total++;
                if (obs_done[i] !== (i == 9)) begin bad++; $display("FAIL rand_done n=%0d idx=%0d got=%b want=%b", n, i, obs_done[i], (i == 9)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_even_a5();
        test_odd_parity();
        test_no_parity();
        test_mid_frame_dv();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
